// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder: IO region decode, register
// offsets, status bit positions and the mem_wr encoding.
package mem_responder_pkg;

  localparam logic [1:0] IoRegionTag = 2'b11;
  localparam logic [2:0] IoOffData   = 3'd0;
  localparam logic [2:0] IoOffStat   = 3'd4;

  localparam int StatTxFull    = 0;
  localparam int StatRxNonempty = 1;
  localparam int StatTxOvf     = 2;

  localparam logic Read  = 1'b0;
  localparam logic Write = 1'b1;

endpackage

// File: rtl/mem_responder_byte_fifo.sv
// Byte FIFO with power-of-2 depth; pointers carry one extra wrap bit so
// full and empty are told apart without a separate counter.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] PtrOne = (IW + 1)'(1);

  logic [7:0]  mem [DEPTH];
  logic [IW:0] wr_ptr;
  logic [IW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IW] != rd_ptr[IW]) &&
                 (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

  // A pop on a full FIFO frees the slot the simultaneous push lands in;
  // a pop on an empty FIFO is ignored even when a push arrives with it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = empty ? 8'h00 : mem[rd_ptr[IW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrOne;
      if (do_pop)  rd_ptr <= rd_ptr + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IW-1:0]] <= din;
  end

endmodule

// File: rtl/mem_responder.sv
// Byte-wide memory responder: synchronous RAM below the IO region, and a
// TX FIFO, RX FIFO and status register mapped at mem_a[17:16] == 2'b11.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int RAM_AW     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  // Handshake: a TX byte transfers on any rising edge where tx_valid and
  // tx_ready are both high; tx_data is stable while tx_valid waits.
  // rx_valid is a one-cycle push strobe with no back-pressure.

  logic [7:0] ram [2**RAM_AW];

  logic       io_sel;
  logic [2:0] io_off;
  logic       is_rd;
  logic       is_wr;
  logic       rd0;
  logic       prev_rd0;
  logic       tx_push;
  logic       tx_pop;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_ovf;
  logic       ovf_clr;
  logic       rx_pop;
  logic       rx_full;
  logic       rx_empty;
  logic [7:0] rx_head;
  logic [7:0] status;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^mem_a[31:18];

  assign io_sel  = (mem_a[17:16] == IoRegionTag);
  assign io_off  = mem_a[2:0];
  assign is_rd   = (mem_wr == Read);
  assign is_wr   = (mem_wr == Write);
  assign rd0     = is_rd && io_sel && (io_off == IoOffData);
  // A held offset-0 read pops only once, on its first cycle.
  assign rx_pop  = rd0 && !prev_rd0;
  assign tx_push = is_wr && io_sel && (io_off == IoOffData);
  assign ovf_clr = is_wr && io_sel && (io_off == IoOffStat);
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;

  always_comb begin
    status                 = 8'h00;
    status[StatTxFull]     = tx_full;
    status[StatRxNonempty] = !rx_empty;
    status[StatTxOvf]      = tx_ovf;
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (mem_dout),
    .pop   (tx_pop),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .din   (rx_data),
    .pop   (rx_pop),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_ff @(posedge clk) begin
    if (is_wr && !io_sel) ram[mem_a[RAM_AW-1:0]] <= mem_dout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_din  <= 8'h00;
      prev_rd0 <= 1'b0;
      tx_ovf   <= 1'b0;
    end else begin
      prev_rd0 <= rd0;
      // A write that finds the TX FIFO full is lost unless a drain frees a slot.
      if (tx_push && tx_full && !tx_pop) tx_ovf <= 1'b1;
      else if (ovf_clr)                  tx_ovf <= 1'b0;
      if (is_rd) begin
        if (!io_sel) begin
          mem_din <= ram[mem_a[RAM_AW-1:0]];
        end else begin
          case (io_off)
            IoOffData: mem_din <= rx_head;
            IoOffStat: mem_din <= status;
            default:   mem_din <= 8'h00;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM access, TX/RX FIFOs, status
// register, held-read pop behaviour and asynchronous reset.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic [7:0] exp_q[$];
  logic [7:0] tx_exp_q[$];
  int total = 0;
  int bad   = 0;

  mem_responder #(.RAM_AW(17), .FIFO_DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_a    (mem_a),
    .mem_wr   (mem_wr),
    .mem_dout (mem_dout),
    .mem_din  (mem_din),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    mem_a  = 32'h0000_0010;
    mem_wr = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_a    = a;
    mem_wr   = 1'b1;
    mem_dout = d;
    tick();
    idle();
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [7:0] e);
    mem_a  = a;
    mem_wr = 1'b0;
    exp_q.push_back(e);
    tick();
    chk(tag, mem_din, exp_q.pop_front());
  endtask

  initial begin
    rst      = 1'b0;
    mem_a    = 32'h0000_0010;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
    tx_ready = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    #3;
    chk("rst_mem_din", mem_din, 8'h00);
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    #4 rst = 1'b1;
    tick();

    // RAM write then read, then a write must not disturb mem_din
    wr(32'h0000_0010, 8'hA5);
    rd("ram_rd_a5", 32'h0000_0010, 8'hA5);
    wr(32'h0000_0020, 8'h3C);
    idle();
    mem_a = 32'h0003_0001;  // IO read of an unused offset would clear mem_din
    mem_wr = 1'b1;          // ...but this is a write, so mem_din must hold
    mem_dout = 8'hEE;
    tick();
    chk("wr_holds_din", mem_din, 8'hA5);
    rd("ram_rd_3c", 32'h0000_0020, 8'h3C);
    rd("io_unused_off", 32'h0003_0002, 8'h00);

    // controller-style back-to-back reads
    for (int i = 0; i < 4; i++) wr(32'h0000_0100 + i, 8'h11 * (i + 1));
    for (int i = 0; i < 4; i++) begin
      mem_a  = 32'h0000_0100 + i;
      mem_wr = 1'b0;
      exp_q.push_back(8'h11 * (i + 1));
      tick();
      chk($sformatf("burst_rd%0d", i), mem_din, exp_q.pop_front());
    end
    idle();
    tick();

    // TX path
    wr(32'h0003_0000, 8'h41);
    chk("tx_valid_up", {7'b0, tx_valid}, 8'h01);
    chk("tx_data_41", tx_data, 8'h41);
    tx_ready = 1'b1;
    tick();
    chk("tx_valid_drop", {7'b0, tx_valid}, 8'h00);
    tx_ready = 1'b0;

    // TX overflow, status, clear, then drain in order
    for (int i = 0; i < 9; i++) begin
      wr(32'h0003_0000, 8'h50 + i);
      if (i < 8) tx_exp_q.push_back(8'h50 + i);
    end
    rd("stat_ovf", 32'h0003_0004, 8'h05);
    wr(32'h0003_0004, 8'hFF);
    rd("stat_ovf_clr", 32'h0003_0004, 8'h01);
    rd("stat_alias", 32'h0003_FFFC, 8'h01);
    idle();
    tx_ready = 1'b1;
    for (int g = 0; g < 20 && tx_exp_q.size() != 0; g++) begin
      if (tx_valid) chk("tx_drain", tx_data, tx_exp_q.pop_front());
      tick();
    end
    chk("tx_drain_left", 8'(tx_exp_q.size()), 8'h00);
    chk("tx_drained", {7'b0, tx_valid}, 8'h00);
    tx_ready = 1'b0;

    // RX pop qualification
    rx_valid = 1'b1;
    rx_data = 8'h7E; tick();
    rx_data = 8'h7F; tick();
    rx_valid = 1'b0;
    mem_a  = 32'h0003_0000;
    mem_wr = 1'b0;
    tick();
    chk("rx_hold_first", mem_din, 8'h7E);
    tick();
    tick();
    rd("rx_stat_queued", 32'h0003_0004, 8'h02);
    rd("rx_7f", 32'h0003_0000, 8'h7F);
    rd("rx_empty_00", 32'h0003_0000, 8'h00);
    idle();

    // RX overflow: ninth byte dropped
    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_data = 8'h90 + i;
      tick();
    end
    rx_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rd($sformatf("rx_fill%0d", i), 32'h0003_0000, (i < 8) ? 8'(8'h90 + i) : 8'h00);
      idle();
      tick();
    end

    // asynchronous reset mid TX drain
    for (int i = 0; i < 3; i++) wr(32'h0003_0000, 8'hC0 + i);
    rd("pre_rst_ram", 32'h0000_0010, 8'hA5);
    idle();
    tx_ready = 1'b1;
    tick();
    chk("pre_rst_tx_data", tx_data, 8'hC1);
    #2 rst = 1'b0;
    #1;
    chk("arst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("arst_mem_din", mem_din, 8'h00);
    chk("arst_tx_data", tx_data, 8'h00);
    #2 rst = 1'b1;
    tx_ready = 1'b0;
    tick();
    rd("post_rst_stat", 32'h0003_0004, 8'h00);
    rd("post_rst_ram", 32'h0000_0010, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
